// File: rtl/irq_prio_ctrl.sv
// rtl/irq_prio_ctrl.sv - clocked priority interrupt controller with pending latches, mask and irq/ack handshake
// Optional IRQ_EDGE_EN: pend lines on rising request edges instead of levels.
module irq_prio_ctrl #(
    parameter int NCH  = 9,
    parameter int NBUS = 3,
    parameter int VW   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*NBUS-1:0]    req_i,
    input  logic                   mask_we,
    input  logic [NCH*NBUS-1:0]    mask_din,
    input  logic                   ack_i,
    output logic                   irq_o,
    output logic [VW-1:0]          vec_o,
    output logic [NCH*NBUS-1:0]    pend_o
);

    localparam int N = NCH * NBUS;

    if ((2 ** VW) < N) begin : g_vw_check
        $error("irq_prio_ctrl: VW too narrow for NCH*NBUS lines");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   pend;
    logic [N-1:0]   mask;
    logic [N-1:0]   elig;
    logic [N-1:0]   set_vec;
    logic [N-1:0]   clr_vec;
    logic [VW-1:0]  win;
    logic           any_elig;
    logic           ack_take;

`ifdef IRQ_EDGE_EN
    logic [N-1:0]   req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_i;
        end
    end

    assign set_vec = req_i & ~req_q;
`else
    assign set_vec = req_i;
`endif

    assign elig     = pend & ~mask;
    assign any_elig = |elig;
    assign ack_take = (state == ASSERT) && ack_i;

    // Lowest flat index wins, so scan from the top and let lower indices overwrite.
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win = VW'(i);
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        if (ack_take) begin
            clr_vec = N'(1) << vec_o;
        end
    end

    // Clear of the serviced line beats a simultaneous set of the same line.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend | set_vec) & ~clr_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '1;
        end else if (mask_we) begin
            mask <= mask_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_o <= '0;
        end else if ((state == IDLE) && any_elig) begin
            vec_o <= win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_elig) state_nxt = ASSERT;
            ASSERT:  if (ack_i)    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq_o = (state == ASSERT);
    end

    assign pend_o = pend;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb/tb_irq_prio_ctrl.sv - directed self-checking bench for irq_prio_ctrl
module tb_irq_prio_ctrl;

    localparam int NCH  = 9;
    localparam int NBUS = 3;
    localparam int VW   = 5;
    localparam int N    = NCH * NBUS;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic           mask_we = 1'b0;
    logic [N-1:0]   mask_din = '0;
    logic           ack_i = 1'b0;
    logic           irq_o;
    logic [VW-1:0]  vec_o;
    logic [N-1:0]   pend_o;

    int tests = 0;
    int fails = 0;

    irq_prio_ctrl #(.NCH(NCH), .NBUS(NBUS), .VW(VW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .ack_i    (ack_i),
        .irq_o    (irq_o),
        .vec_o    (vec_o),
        .pend_o   (pend_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL reset_irq got %0b want 0", irq_o); end
        tests++; if (vec_o !== 5'd0) begin fails++; $display("FAIL reset_vec got %0d want 0", vec_o); end
        tests++; if (pend_o !== '0) begin fails++; $display("FAIL reset_pend got %h want 0", pend_o); end
    endtask

    task automatic test_mask();
        req_i = N'(1) << 3;
        step();
        req_i = '0;
        step();
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL masked_irq got %0b want 0", irq_o); end
        tests++; if (pend_o !== N'(27'h8)) begin fails++; $display("FAIL masked_pend got %h want 8", pend_o); end
        mask_we = 1'b1; mask_din = '0;
        step();
        mask_we = 1'b0;
        step();
        tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL unmask_irq got %0b want 1", irq_o); end
        tests++; if (vec_o !== 5'd3) begin fails++; $display("FAIL unmask_vec got %0d want 3", vec_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        tests++; if (irq_o !== 1'b0 || pend_o !== '0) begin fails++; $display("FAIL ack3 irq %0b pend %h want 0 0", irq_o, pend_o); end
        step();
        step();
    endtask

    task automatic test_two_pulse();
        req_i = (N'(1) << 20) | (N'(1) << 7);
        step();
        req_i = '0;
        step();
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd7) begin fails++; $display("FAIL pair_first irq %0b vec %0d want 1 7", irq_o, vec_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL pair_gap irq got %0b want 0", irq_o); end
        tests++; if (pend_o !== N'(1) << 20) begin fails++; $display("FAIL pair_gap_pend got %h want %h", pend_o, N'(1) << 20); end
        step();
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL pair_idle irq got %0b want 0", irq_o); end
        step();
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd20) begin fails++; $display("FAIL pair_second irq %0b vec %0d want 1 20", irq_o, vec_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        tests++; if (irq_o !== 1'b0 || pend_o !== '0) begin fails++; $display("FAIL pair_done irq %0b pend %h want 0 0", irq_o, pend_o); end
        step();
        step();
    endtask

    task automatic test_freeze();
        req_i = N'(1) << 12;
        step();
        req_i = N'(1);
        step();
        req_i = '0;
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd12) begin fails++; $display("FAIL freeze_vec irq %0b vec %0d want 1 12", irq_o, vec_o); end
        tests++; if (pend_o !== ((N'(1) << 12) | N'(1))) begin fails++; $display("FAIL freeze_pend got %h want %h", pend_o, (N'(1) << 12) | N'(1)); end
        mask_we = 1'b1; mask_din = '1;
        step();
        mask_din = '0;
        step();
        mask_we = 1'b0;
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd12) begin fails++; $display("FAIL freeze_masked irq %0b vec %0d want 1 12", irq_o, vec_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        step();
        step();
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd0) begin fails++; $display("FAIL freeze_next irq %0b vec %0d want 1 0", irq_o, vec_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        step();
        step();
    endtask

    task automatic test_hold();
        req_i = N'(1) << 5;
        step();
        step();
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd5) begin fails++; $display("FAIL hold_first irq %0b vec %0d want 1 5", irq_o, vec_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        tests++; if (pend_o !== '0) begin fails++; $display("FAIL hold_ack_clear got %h want 0", pend_o); end
        step();
`ifdef IRQ_EDGE_EN
        tests++; if (pend_o !== '0) begin fails++; $display("FAIL hold_repend got %h want 0", pend_o); end
        step();
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL hold_reassert irq got %0b want 0", irq_o); end
`else
        tests++; if (pend_o !== N'(1) << 5) begin fails++; $display("FAIL hold_repend got %h want %h", pend_o, N'(1) << 5); end
        step();
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd5) begin fails++; $display("FAIL hold_reassert irq %0b vec %0d want 1 5", irq_o, vec_o); end
`endif
        req_i = '0;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        step();
        step();
        tests++; if (irq_o !== 1'b0 || pend_o !== '0) begin fails++; $display("FAIL hold_drain irq %0b pend %h want 0 0", irq_o, pend_o); end
    endtask

    task automatic test_reset_mid();
        req_i = N'(1) << 9;
        step();
        req_i = '0;
        step();
        tests++; if (irq_o !== 1'b1 || vec_o !== 5'd9) begin fails++; $display("FAIL mid_assert irq %0b vec %0d want 1 9", irq_o, vec_o); end
        rst = 1'b1;
        req_i = N'(1) << 4;
        step();
        rst = 1'b0;
        req_i = '0;
        tests++; if (irq_o !== 1'b0 || pend_o !== '0 || vec_o !== 5'd0) begin fails++; $display("FAIL mid_reset irq %0b pend %h vec %0d want 0 0 0", irq_o, pend_o, vec_o); end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL mid_late_ack irq got %0b want 0", irq_o); end
        req_i = N'(1) << 2;
        step();
        req_i = '0;
        step();
        step();
        tests++; if (irq_o !== 1'b0 || pend_o !== N'(1) << 2) begin fails++; $display("FAIL mid_mask_ones irq %0b pend %h want 0 %h", irq_o, pend_o, N'(1) << 2); end
    endtask

    task automatic test_idle_ack();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (irq_o !== 1'b0 || pend_o !== '0 || vec_o !== 5'd0) begin fails++; $display("FAIL idle_ack cyc %0d irq %0b pend %h vec %0d want 0 0 0", k, irq_o, pend_o, vec_o); end
        end
        ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mask();
        test_two_pulse();
        test_freeze();
        test_hold();
        test_reset_mid();
        test_idle_ack();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests %0d want completion", tests);
        $fatal(1, "timeout");
    end

endmodule
